// File: rtl/axis_drop_buffer_pkg.sv
// rtl/axis_drop_buffer_pkg.sv - shared defaults and write-side action type for axis_drop_buffer
package axis_drop_buffer_pkg;

    localparam int DEF_DATA_WIDTH = 9;
    localparam int DEF_BUF_WIDTH  = 11;

    // One decision per cycle on the producer side; drop and wr_en are mutually exclusive.
    typedef struct packed {
        logic wr_en;
        logic commit;
        logic drop;
        logic ovf_set;
    } wr_action_t;

endpackage

// File: rtl/axis_drop_buffer_sdp_ram.sv
// rtl/axis_drop_buffer_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module sdp_ram #(
    parameter int WIDTH      = 10,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0] rd_data_q;

    // Read data holds when rd_en is low; this is what keeps a stalled output stable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_drop_buffer.sv
// rtl/axis_drop_buffer.sv - RX packet buffer that commits whole packets and drops cancelled or overflowed ones
module axis_drop_buffer
    import axis_drop_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUF_WIDTH  = DEF_BUF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    input  logic                  cancel,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic                  dropped
);

    localparam int PW    = BUF_WIDTH + 1;
    localparam int DEPTH = 2**BUF_WIDTH;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic          dropped_q, dropped_d;

    wr_action_t    act;
    logic [PW-1:0] fill;
    logic          full, avail, hs, pending, stall, rd_en;
    logic [DATA_WIDTH:0] rd_data;

    always_comb begin
        fill    = wr_ptr_q - rd_ptr_q;
        full    = (fill == PW'(DEPTH));
        avail   = (commit_ptr_q != rd_ptr_q);
        pending = (wr_ptr_q != commit_ptr_q);
        hs      = s_axis_valid & s_ready_q;

        act       = '0;
        dropped_d = 1'b0;
        // Cancel outranks everything, including a last-beat commit in the same cycle.
        if (cancel) begin
            act.drop  = 1'b1;
            dropped_d = pending | ovf_q;
        end else if (hs) begin
            if (full || ovf_q) begin
                if (s_axis_last) begin
                    act.drop  = 1'b1;
                    dropped_d = 1'b1;
                end else begin
                    act.ovf_set = 1'b1;
                end
            end else begin
                act.wr_en  = 1'b1;
                act.commit = s_axis_last;
            end
        end

        wr_ptr_d     = act.wr_en  ? wr_ptr_q + PW'(1) :
                       act.drop   ? commit_ptr_q      : wr_ptr_q;
        commit_ptr_d = act.commit ? wr_ptr_q + PW'(1) : commit_ptr_q;
        ovf_d        = act.drop   ? 1'b0 : (act.ovf_set ? 1'b1 : ovf_q);
        s_ready_d    = 1'b1;

        // Output register: refill whenever it is not holding an unaccepted beat.
        stall     = m_valid_q & ~m_axis_ready;
        rd_en     = ~stall & avail;
        rd_ptr_d  = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
        m_valid_d = stall | avail;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            dropped_q    <= dropped_d;
        end
    end

    sdp_ram #(
        .WIDTH      (DATA_WIDTH + 1),
        .DEPTH_LOG2 (BUF_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (act.wr_en),
        .wr_addr (wr_ptr_q[BUF_WIDTH-1:0]),
        .wr_data ({s_axis_last, s_axis_data}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[BUF_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    assign s_axis_ready = s_ready_q;
    assign m_axis_valid = m_valid_q;
    // RAM output is not reset, so last is qualified by valid.
    assign m_axis_last  = m_valid_q & rd_data[DATA_WIDTH];
    assign m_axis_data  = rd_data[DATA_WIDTH-1:0];
    assign dropped      = dropped_q;

endmodule

// File: tb/tb_axis_drop_buffer.sv
// tb/tb_axis_drop_buffer.sv - self-checking bench for axis_drop_buffer with a queue-based packet model
module tb_axis_drop_buffer;

    localparam int DW    = 9;
    localparam int BW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0, s_last = 1'b0, cancel = 1'b0, m_ready = 1'b0;
    logic          s_ready_o, m_valid_o, m_last_o, dropped_o;
    logic [DW-1:0] m_data_o;

    axis_drop_buffer #(.DATA_WIDTH(DW), .BUF_WIDTH(BW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (s_data),
        .s_axis_valid (s_valid),
        .s_axis_ready (s_ready_o),
        .s_axis_last  (s_last),
        .cancel       (cancel),
        .m_axis_data  (m_data_o),
        .m_axis_valid (m_valid_o),
        .m_axis_ready (m_ready),
        .m_axis_last  (m_last_o),
        .dropped      (dropped_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    // Model: beats of the open packet, committed beats not yet in the output register,
    // the output register itself, and a history of beats the consumer accepted.
    logic [DW:0] pend_q[$];
    logic [DW:0] com_q[$];
    logic [DW:0] deliv_q[$];
    logic [DW:0] sent_q[$];
    logic [DW:0] mo_ent = '0;
    bit          mo_valid = 0, mo_ready = 0, mo_drop = 0, mo_ovf = 0;
    int          drop_cnt = 0;
    bit          full, hs, nd;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            pend_q.delete();
            com_q.delete();
            mo_ovf = 0; mo_ready = 0; mo_valid = 0; mo_drop = 0;
        end else begin
            full = (pend_q.size() + com_q.size()) == DEPTH;
            if (mo_valid && m_ready) deliv_q.push_back(mo_ent);
            if (!(mo_valid && !m_ready)) begin
                if (com_q.size() > 0) begin
                    mo_ent = com_q.pop_front();
                    mo_valid = 1;
                end else begin
                    mo_valid = 0;
                end
            end
            hs = s_valid && mo_ready;
            nd = 0;
            if (cancel) begin
                nd = (pend_q.size() > 0) || mo_ovf;
                pend_q.delete();
                mo_ovf = 0;
            end else if (hs) begin
                if (full || mo_ovf) begin
                    if (s_last) begin
                        nd = 1;
                        pend_q.delete();
                        mo_ovf = 0;
                    end else begin
                        mo_ovf = 1;
                    end
                end else begin
                    pend_q.push_back({s_last, s_data});
                    if (s_last) begin
                        foreach (pend_q[i]) com_q.push_back(pend_q[i]);
                        pend_q.delete();
                    end
                end
            end
            mo_drop = nd;
            if (nd) drop_cnt++;
            mo_ready = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("s_axis_ready", s_ready_o, mo_ready);
            chk("m_axis_valid", m_valid_o, mo_valid);
            chk("dropped", dropped_o, mo_drop);
            chk("m_axis_last", m_last_o, mo_valid & mo_ent[DW]);
            if (mo_valid) chk("m_axis_data", m_data_o, mo_ent[DW-1:0]);
        end
    end

    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit l, input bit c);
        s_valid = v; s_data = d; s_last = l; cancel = c;
        @(negedge clk);
    endtask

    task automatic drain();
        int w;
        m_ready = 1;
        for (w = 0; w < 60; w++) begin
            if (com_q.size() == 0 && !mo_valid && pend_q.size() == 0) break;
            cyc(0, '0, 0, 0);
        end
        if (w == 60) chk("drain_timeout", 1, 0);
    endtask

    int d0, b;

    initial begin
        @(negedge clk);
        rst = 1;
        cyc(0, '0, 0, 0);
        cmp_en = 1;
        cyc(0, '0, 0, 0);
        chk("reset_s_ready", s_ready_o, 0);
        chk("reset_m_valid", m_valid_o, 0);
        chk("reset_m_last", m_last_o, 0);
        chk("reset_dropped", dropped_o, 0);
        rst = 0;
        cyc(0, '0, 0, 0);
        chk("s_ready_after_reset", s_ready_o, 1);

        // 3-beat packet, latency and order
        m_ready = 1; b = deliv_q.size();
        cyc(1, 9'h11, 0, 0); cyc(1, 9'h22, 0, 0); cyc(1, 9'h13, 1, 0);
        chk("t1_not_yet_valid", m_valid_o, 0);
        cyc(0, '0, 0, 0);
        chk("t1_b0_valid", m_valid_o, 1); chk("t1_b0_data", m_data_o, 'h11); chk("t1_b0_last", m_last_o, 0);
        cyc(0, '0, 0, 0);
        chk("t1_b1_data", m_data_o, 'h22); chk("t1_b1_last", m_last_o, 0);
        cyc(0, '0, 0, 0);
        chk("t1_b2_data", m_data_o, 'h13); chk("t1_b2_last", m_last_o, 1); chk("t1_dropped", dropped_o, 0);
        cyc(0, '0, 0, 0);
        chk("t1_idle_valid", m_valid_o, 0);
        chk("t1_model_count", deliv_q.size() - b, 3);
        chk("t1_model_b2", deliv_q[b+2], 10'h213);

        // cancel on beat 3, then a clean 2-beat packet
        d0 = drop_cnt; b = deliv_q.size();
        cyc(1, 9'h31, 0, 0); cyc(1, 9'h32, 0, 0); cyc(1, 9'h33, 0, 1);
        chk("t2_drop_pulse", dropped_o, 1);
        cyc(0, '0, 0, 0);
        chk("t2_drop_once", dropped_o, 0);
        cyc(1, 9'hA0, 0, 0); cyc(1, 9'hA1, 1, 0);
        drain();
        chk("t2_drops", drop_cnt - d0, 1);
        chk("t2_count", deliv_q.size() - b, 2);
        chk("t2_first", deliv_q[b], 10'h0A0);
        chk("t2_second", deliv_q[b+1], 10'h2A1);

        // overflow of a 10-beat packet into an 8-entry buffer
        m_ready = 0; d0 = drop_cnt; b = deliv_q.size();
        for (int i = 1; i <= 10; i++) cyc(1, DW'(i), i == 10, 0);
        chk("t3_drop_pulse", dropped_o, 1);
        cyc(0, '0, 0, 0);
        chk("t3_nothing_out", m_valid_o, 0);
        chk("t3_drops", drop_cnt - d0, 1);
        m_ready = 1;
        cyc(1, 9'h0C1, 0, 0); cyc(1, 9'h0C2, 1, 0);
        drain();
        chk("t3_count", deliv_q.size() - b, 2);
        chk("t3_second", deliv_q[b+1], 10'h2C2);

        // back-to-back 3-beat packets with random consumer stalls
        d0 = drop_cnt; b = deliv_q.size(); sent_q.delete();
        for (int p = 0; p < 20; p++) begin
            for (int w = 0; w < 100 && (com_q.size() + pend_q.size()) > 4; w++) begin
                m_ready = 1'($urandom_range(0, 1));
                cyc(0, '0, 0, 0);
            end
            for (int k = 0; k < 3; k++) begin
                logic [DW-1:0] d;
                d = DW'($urandom_range(0, 511));
                sent_q.push_back({k == 2, d});
                m_ready = 1'($urandom_range(0, 1));
                cyc(1, d, k == 2, 0);
            end
        end
        drain();
        chk("t4_drops", drop_cnt - d0, 0);
        chk("t4_count", deliv_q.size() - b, 60);
        if (deliv_q.size() - b == 60)
            for (int i = 0; i < 60; i++) chk("t4_seq", deliv_q[b+i], sent_q[i]);

        // cancel on last beat, then cancel while idle
        d0 = drop_cnt; b = deliv_q.size();
        cyc(1, 9'h51, 0, 0); cyc(1, 9'h52, 0, 0); cyc(1, 9'h53, 1, 1);
        chk("t5_drop_pulse", dropped_o, 1);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 1);
        chk("t5_idle_cancel", dropped_o, 0);
        drain();
        chk("t5_nothing_out", deliv_q.size() - b, 0);
        chk("t5_drops", drop_cnt - d0, 1);

        // reset mid-packet while the output is stalled
        m_ready = 0;
        cyc(1, 9'h61, 1, 0); cyc(0, '0, 0, 0); cyc(0, '0, 0, 0);
        chk("t6_stalled_valid", m_valid_o, 1);
        cyc(1, 9'h71, 0, 0);
        rst = 1;
        cyc(1, 9'h72, 0, 0);
        chk("t6_rst_valid", m_valid_o, 0);
        chk("t6_rst_ready", s_ready_o, 0);
        rst = 0;
        cyc(0, '0, 0, 0);
        chk("t6_ready_back", s_ready_o, 1);
        m_ready = 1; b = deliv_q.size();
        cyc(1, 9'h81, 0, 0); cyc(1, 9'h82, 1, 0);
        drain();
        chk("t6_count", deliv_q.size() - b, 2);
        chk("t6_first", deliv_q[b], 10'h081);

        // random mixed traffic, checked by the per-cycle compare
        for (int i = 0; i < 600; i++) begin
            m_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            cyc($urandom_range(0, 3) != 0, DW'($urandom_range(0, 511)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
